// File: rtl/biriscv_v_wb_arbiter_pkg.sv
// Shared vector writeback definitions: default register width, register-index
// width, the x0/v0 "no write" index and the arbiter state encoding.
package biriscv_v_pkg;

  localparam int VLEN_DEFAULT = 128;
  localparam int REG_W        = 5;
  localparam int NUM_REGS     = 1 << REG_W;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  // Arbitration state: normal round-robin, or locked onto an LSU burst
  typedef enum logic {
    ARB      = 1'b0,
    LOCK_LSU = 1'b1
  } arb_state_t;

  // Round-robin priority pointer: which requester wins a tie
  typedef enum logic {
    PTR_ALU = 1'b0,
    PTR_LSU = 1'b1
  } arb_ptr_t;

endpackage

// File: rtl/biriscv_v_wb_arbiter_if.sv
// Writeback bus between the vector ALU / load unit / issue stage and the
// writeback arbiter. The master modport is the requesting side, the slave
// modport is the arbiter.
interface biriscv_v_wb_arbiter_if #(
  parameter int VLEN = 128
);

  logic             alu_valid_i;
  logic [4:0]       alu_rd_i;
  logic [VLEN-1:0]  alu_data_i;
  logic             alu_ready_o;

  logic             lsu_valid_i;
  logic [4:0]       lsu_rd_i;
  logic [VLEN-1:0]  lsu_data_i;
  logic             lsu_last_i;
  logic             lsu_ready_o;

  logic             issue_valid_i;
  logic [4:0]       issue_rd_i;
  logic [4:0]       rs1_i;
  logic [4:0]       rs2_i;
  logic             hazard_o;

  logic [4:0]       rd0_o;
  logic [VLEN-1:0]  rd0_value_o;
  logic [31:0]      busy_o;

  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
    input  alu_ready_o,
    output lsu_valid_i, lsu_rd_i, lsu_data_i, lsu_last_i,
    input  lsu_ready_o,
    output issue_valid_i, issue_rd_i, rs1_i, rs2_i,
    input  hazard_o,
    input  rd0_o, rd0_value_o, busy_o
  );

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
    output alu_ready_o,
    input  lsu_valid_i, lsu_rd_i, lsu_data_i, lsu_last_i,
    output lsu_ready_o,
    input  issue_valid_i, issue_rd_i, rs1_i, rs2_i,
    output hazard_o,
    output rd0_o, rd0_value_o, busy_o
  );

endinterface

// File: rtl/biriscv_v_wb_arbiter_scoreboard.sv
// Vector register scoreboard: one pending-write bit per register, set on
// issue and cleared when the write reaches the register file. A set in the
// same cycle as a clear wins, and register 0 is never tracked.
module biriscv_v_scoreboard
  import biriscv_v_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_valid_i,
  input  logic [REG_W-1:0]  issue_rd_i,
  input  logic [REG_W-1:0]  rs1_i,
  input  logic [REG_W-1:0]  rs2_i,
  input  logic [REG_W-1:0]  wr_rd_i,
  output logic              hazard_o,
  output logic [NUM_REGS-1:0] busy_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Next pending set: clear the written register first so a new reservation wins
  always_comb begin
    busy_d = busy_q;
    if (wr_rd_i != REG_ZERO) begin
      busy_d[wr_rd_i] = 1'b0;
    end
    if (issue_valid_i && (issue_rd_i != REG_ZERO)) begin
      busy_d[issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Pending-write register, cleared by the synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Stall the candidate when any operand or its destination is still pending
  always_comb begin
    hazard_o = busy_q[rs1_i] | busy_q[rs2_i] | busy_q[issue_rd_i];
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/biriscv_v_wb_arbiter.sv
// Vector writeback arbiter: round-robin between the vector ALU and the vector
// load unit onto the single register-file write port, registered one cycle.
// Optional macro BIRISCV_V_WB_LOCK_EN holds the port for a whole LSU burst
// (until lsu_last_i); without it every beat is arbitrated independently.
module biriscv_v_wb_arbiter
  import biriscv_v_pkg::*;
#(
  parameter int VLEN = VLEN_DEFAULT
)(
  input  logic                  clk_i,
  input  logic                  rst_i,
  biriscv_v_wb_arbiter_if.slave bus
);

  arb_ptr_t          ptr_q;
  arb_ptr_t          ptr_d;
  logic              alu_ready;
  logic              lsu_ready;
  logic              alu_grant;
  logic              lsu_grant;
  logic [REG_W-1:0]  rd0_q;
  logic [VLEN-1:0]   rd0_value_q;

`ifdef BIRISCV_V_WB_LOCK_EN
  arb_state_t        state_q;
  arb_state_t        state_d;

  // Arbitration state register; reset abandons any LSU burst in progress
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end
`endif

  // Ready/grant decode and next state; nothing is granted while in reset
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
`ifdef BIRISCV_V_WB_LOCK_EN
    state_d   = state_q;
`endif
    if (rst_i) begin
`ifdef BIRISCV_V_WB_LOCK_EN
      if (state_q == LOCK_LSU) begin
        lsu_ready = bus.lsu_valid_i;
      end else
`endif
      if (bus.alu_valid_i && bus.lsu_valid_i) begin
        alu_ready = (ptr_q == PTR_ALU);
        lsu_ready = (ptr_q == PTR_LSU);
      end else begin
        alu_ready = bus.alu_valid_i;
        lsu_ready = bus.lsu_valid_i;
      end
    end
    alu_grant = bus.alu_valid_i & alu_ready;
    lsu_grant = bus.lsu_valid_i & lsu_ready;
`ifdef BIRISCV_V_WB_LOCK_EN
    if (lsu_grant) begin
      state_d = bus.lsu_last_i ? ARB : LOCK_LSU;
    end
`endif
  end

  // Priority pointer moves to whichever requester was not just granted
  always_comb begin
    ptr_d = ptr_q;
    if (alu_grant) begin
      ptr_d = PTR_LSU;
    end else if (lsu_grant) begin
      ptr_d = PTR_ALU;
    end
  end

  // Pointer register, ALU has priority out of reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ptr_q <= PTR_ALU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Write stage: granted beat goes to the regfile next cycle, data holds when idle
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rd0_q       <= REG_ZERO;
      rd0_value_q <= '0;
    end else if (alu_grant) begin
      rd0_q       <= bus.alu_rd_i;
      rd0_value_q <= bus.alu_data_i;
    end else if (lsu_grant) begin
      rd0_q       <= bus.lsu_rd_i;
      rd0_value_q <= bus.lsu_data_i;
    end else begin
      rd0_q       <= REG_ZERO;
    end
  end

  biriscv_v_scoreboard u_scoreboard (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .issue_valid_i (bus.issue_valid_i),
    .issue_rd_i    (bus.issue_rd_i),
    .rs1_i         (bus.rs1_i),
    .rs2_i         (bus.rs2_i),
    .wr_rd_i       (rd0_q),
    .hazard_o      (bus.hazard_o),
    .busy_o        (bus.busy_o)
  );

  assign bus.alu_ready_o = alu_ready;
  assign bus.lsu_ready_o = lsu_ready;
  assign bus.rd0_o       = rd0_q;
  assign bus.rd0_value_o = rd0_value_q;

endmodule

// File: tb/tb_biriscv_v_wb_arbiter.sv
// Directed bench for the vector writeback arbiter. Inputs change 1 ns after
// the rising edge; registered outputs are sampled at that point and
// combinational outputs 1 ns after the new inputs settle.
module tb_biriscv_v_wb_arbiter;

  localparam int VLEN = 128;

  localparam logic [VLEN-1:0] DATA_A = {4{32'hAAAA_0001}};
  localparam logic [VLEN-1:0] DATA_B = {4{32'hBBBB_0002}};
  localparam logic [VLEN-1:0] DATA_C = {4{32'hCCCC_0003}};
  localparam logic [VLEN-1:0] DATA_D = {4{32'hDDDD_0004}};
  localparam logic [VLEN-1:0] ONES   = '1;

  logic clk;
  logic rst;
  int   testCount;
  int   failCount;

  biriscv_v_wb_arbiter_if #(.VLEN(VLEN)) bus ();

  biriscv_v_wb_arbiter #(.VLEN(VLEN)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run can never hang
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [VLEN-1:0] obs,
                             input logic [VLEN-1:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive both writeback requesters in one call
  task automatic applyStimulus(input logic aluValid, input logic [4:0] aluRd,
                               input logic [VLEN-1:0] aluData,
                               input logic lsuValid, input logic [4:0] lsuRd,
                               input logic [VLEN-1:0] lsuData, input logic lsuLast);
    bus.alu_valid_i = aluValid;
    bus.alu_rd_i    = aluRd;
    bus.alu_data_i  = aluData;
    bus.lsu_valid_i = lsuValid;
    bus.lsu_rd_i    = lsuRd;
    bus.lsu_data_i  = lsuData;
    bus.lsu_last_i  = lsuLast;
    #1;
  endtask

  // Advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    rst = 1'b0;
    bus.issue_valid_i = 1'b0;
    bus.issue_rd_i    = '0;
    bus.rs1_i         = '0;
    bus.rs2_i         = '0;
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0);

    // Reset: outputs cleared, no ready even with both requesters valid
    tick();
    tick();
    applyStimulus(1'b1, 5'd3, DATA_A, 1'b1, 5'd5, DATA_B, 1'b1);
    checkOutput("rst_alu_ready", bus.alu_ready_o, 0);
    checkOutput("rst_lsu_ready", bus.lsu_ready_o, 0);
    checkOutput("rst_rd0", bus.rd0_o, 0);
    checkOutput("rst_value", bus.rd0_value_o, 0);
    checkOutput("rst_busy", bus.busy_o, 0);

    // Both valid out of reset: ALU first, then LSU
    rst = 1'b1;
    #1;
    checkOutput("rr0_alu_ready", bus.alu_ready_o, 1);
    checkOutput("rr0_lsu_ready", bus.lsu_ready_o, 0);
    tick();
    checkOutput("rr0_rd0", bus.rd0_o, 3);
    checkOutput("rr0_value", bus.rd0_value_o, DATA_A);
    checkOutput("rr1_alu_ready", bus.alu_ready_o, 0);
    checkOutput("rr1_lsu_ready", bus.lsu_ready_o, 1);
    tick();
    checkOutput("rr1_rd0", bus.rd0_o, 5);
    checkOutput("rr1_value", bus.rd0_value_o, DATA_B);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0);
    tick();
    checkOutput("idle_rd0", bus.rd0_o, 0);
    checkOutput("idle_value_hold", bus.rd0_value_o, DATA_B);

    // Reserve v7, then write it back through the ALU
    bus.issue_valid_i = 1'b1;
    bus.issue_rd_i    = 5'd7;
    tick();
    bus.issue_valid_i = 1'b0;
    bus.issue_rd_i    = 5'd0;
    bus.rs1_i         = 5'd7;
    #1;
    checkOutput("sb7_busy_set", bus.busy_o, 32'h0000_0080);
    checkOutput("sb7_hazard", bus.hazard_o, 1);
    applyStimulus(1'b1, 5'd7, DATA_C, 1'b0, 5'd0, '0, 1'b0);
    checkOutput("sb7_alu_ready", bus.alu_ready_o, 1);
    tick();
    checkOutput("sb7_rd0", bus.rd0_o, 7);
    checkOutput("sb7_value", bus.rd0_value_o, DATA_C);
    checkOutput("sb7_busy_during", bus.busy_o, 32'h0000_0080);
    checkOutput("sb7_hazard_during", bus.hazard_o, 1);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0);
    tick();
    checkOutput("sb7_busy_clear", bus.busy_o, 0);
    checkOutput("sb7_hazard_clear", bus.hazard_o, 0);
    bus.rs1_i = 5'd0;

    // v9: a new reservation in the cycle its old write lands keeps it busy
    bus.issue_valid_i = 1'b1;
    bus.issue_rd_i    = 5'd9;
    tick();
    bus.issue_valid_i = 1'b0;
    bus.issue_rd_i    = 5'd0;
    applyStimulus(1'b1, 5'd9, DATA_D, 1'b0, 5'd0, '0, 1'b0);
    tick();
    checkOutput("sb9_rd0", bus.rd0_o, 9);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0);
    bus.issue_valid_i = 1'b1;
    bus.issue_rd_i    = 5'd9;
    tick();
    bus.issue_valid_i = 1'b0;
    bus.issue_rd_i    = 5'd0;
    bus.rs2_i         = 5'd9;
    #1;
    checkOutput("sb9_set_wins", bus.busy_o, 32'h0000_0200);
    checkOutput("sb9_hazard_rs2", bus.hazard_o, 1);
    bus.rs2_i = 5'd0;

    // Register 0 is never reserved and never hazards
    bus.issue_valid_i = 1'b1;
    bus.issue_rd_i    = 5'd0;
    tick();
    bus.issue_valid_i = 1'b0;
    #1;
    checkOutput("sb0_busy", bus.busy_o, 32'h0000_0200);
    checkOutput("sb0_hazard", bus.hazard_o, 0);

    // ALU beat to register 0 is accepted but produces no write
    applyStimulus(1'b1, 5'd0, ONES, 1'b0, 5'd0, '0, 1'b0);
    checkOutput("rd0_zero_ready", bus.alu_ready_o, 1);
    tick();
    checkOutput("rd0_zero_rd0", bus.rd0_o, 0);
    checkOutput("rd0_zero_busy", bus.busy_o, 32'h0000_0200);

    // Pointer now at LSU: tie goes to LSU, then ALU
    applyStimulus(1'b1, 5'd10, DATA_A, 1'b1, 5'd11, DATA_B, 1'b1);
    checkOutput("rr2_lsu_ready", bus.lsu_ready_o, 1);
    checkOutput("rr2_alu_ready", bus.alu_ready_o, 0);
    tick();
    checkOutput("rr2_rd0", bus.rd0_o, 11);
    checkOutput("rr3_alu_ready", bus.alu_ready_o, 1);
    tick();
    checkOutput("rr3_rd0", bus.rd0_o, 10);
    checkOutput("rr3_value", bus.rd0_value_o, DATA_A);

    // Idle cycles leave the pointer at LSU
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0);
    tick();
    tick();
    applyStimulus(1'b1, 5'd10, DATA_A, 1'b1, 5'd11, DATA_B, 1'b1);
    checkOutput("hold_lsu_ready", bus.lsu_ready_o, 1);
    checkOutput("hold_alu_ready", bus.alu_ready_o, 0);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0);

`ifdef BIRISCV_V_WB_LOCK_EN
    // Locked LSU burst of three beats with the ALU waiting throughout
    applyStimulus(1'b1, 5'd12, DATA_C, 1'b1, 5'd1, DATA_A, 1'b0);
    checkOutput("lock1_alu_ready", bus.alu_ready_o, 0);
    checkOutput("lock1_lsu_ready", bus.lsu_ready_o, 1);
    tick();
    checkOutput("lock1_rd0", bus.rd0_o, 1);
    applyStimulus(1'b1, 5'd12, DATA_C, 1'b1, 5'd2, DATA_B, 1'b0);
    checkOutput("lock2_alu_ready", bus.alu_ready_o, 0);
    checkOutput("lock2_lsu_ready", bus.lsu_ready_o, 1);
    tick();
    checkOutput("lock2_rd0", bus.rd0_o, 2);
    applyStimulus(1'b1, 5'd12, DATA_C, 1'b1, 5'd3, DATA_D, 1'b1);
    checkOutput("lock3_alu_ready", bus.alu_ready_o, 0);
    tick();
    checkOutput("lock3_rd0", bus.rd0_o, 3);
    applyStimulus(1'b1, 5'd12, DATA_C, 1'b0, 5'd0, '0, 1'b0);
    checkOutput("unlock_alu_ready", bus.alu_ready_o, 1);
    tick();
    checkOutput("unlock_rd0", bus.rd0_o, 12);
`else
    // Without locking, lsu_last_i low does not hold off the ALU
    applyStimulus(1'b1, 5'd12, DATA_C, 1'b1, 5'd1, DATA_A, 1'b0);
    checkOutput("nolock1_lsu_ready", bus.lsu_ready_o, 1);
    tick();
    checkOutput("nolock1_rd0", bus.rd0_o, 1);
    checkOutput("nolock2_alu_ready", bus.alu_ready_o, 1);
    checkOutput("nolock2_lsu_ready", bus.lsu_ready_o, 0);
    tick();
    checkOutput("nolock2_rd0", bus.rd0_o, 12);
`endif

    // Start a burst (pointer at LSU), then reset for one cycle mid-burst
    applyStimulus(1'b1, 5'd12, DATA_C, 1'b1, 5'd4, DATA_A, 1'b0);
    checkOutput("burst_lsu_ready", bus.lsu_ready_o, 1);
    tick();
    checkOutput("burst_rd0", bus.rd0_o, 4);
    rst = 1'b0;
    #1;
    checkOutput("midrst_alu_ready", bus.alu_ready_o, 0);
    checkOutput("midrst_lsu_ready", bus.lsu_ready_o, 0);
    tick();
    checkOutput("midrst_rd0", bus.rd0_o, 0);
    checkOutput("midrst_value", bus.rd0_value_o, 0);
    checkOutput("midrst_busy", bus.busy_o, 0);
    rst = 1'b1;
    #1;
    checkOutput("postrst_alu_ready", bus.alu_ready_o, 1);
    checkOutput("postrst_lsu_ready", bus.lsu_ready_o, 0);
    tick();
    checkOutput("postrst_rd0", bus.rd0_o, 12);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
